// File: rtl/rr_adder_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit adder between two requesters.
// Captures the winner's operands, runs one add, returns the sum tagged with the requester id.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitrates and captures operands on the grant edge
//   ADD   | gnt pulse high; result registered on the next edge
//   RESP  | rsp_valid pulse high; returns to IDLE
module rr_adder_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_0,
  input  logic [WIDTH-1:0] a_0,
  input  logic [WIDTH-1:0] b_0,
  input  logic             cin_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] b_1,
  input  logic             cin_1,
  output logic             gnt_0,
  output logic             gnt_1,
  output logic             sel,
  output logic             busy,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             rsp_valid,
  output logic             rsp_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_id;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             cin_r;
  logic             winner;
  logic [WIDTH:0]   sum_full;

  // With both requesting, alternate away from the last winner.
  always_comb begin
    winner = req_1;
    if (req_0 && req_1) winner = ~last_id;
  end

  assign sum_full = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      a_r       <= '0;
      b_r       <= '0;
      cin_r     <= 1'b0;
      gnt_0     <= 1'b0;
      gnt_1     <= 1'b0;
      sel       <= 1'b0;
      busy      <= 1'b0;
      sum_out   <= '0;
      cout_out  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_0 || req_1) begin
            state   <= ADD;
            busy    <= 1'b1;
            sel     <= winner;
            last_id <= winner;
            a_r     <= winner ? a_1 : a_0;
            b_r     <= winner ? b_1 : b_0;
            cin_r   <= winner ? cin_1 : cin_0;
            gnt_0   <= ~winner;
            gnt_1   <= winner;
          end
        end
        ADD: begin
          state                <= RESP;
          {cout_out, sum_out}  <= sum_full;
          rsp_id               <= sel;
          rsp_valid            <= 1'b1;
          gnt_0                <= 1'b0;
          gnt_1                <= 1'b0;
        end
        RESP: begin
          state     <= IDLE;
          busy      <= 1'b0;
          rsp_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_adder_arbiter.sv
// Self-checking bench for rr_adder_arbiter: scoreboard of expected responses
// plus per-scenario grant/timing checks.
module tb_rr_adder_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_0, req_1, cin_0, cin_1;
  logic [W-1:0] a_0, b_0, a_1, b_1;
  logic         gnt_0, gnt_1, sel, busy, cout_out, rsp_valid, rsp_id;
  logic [W-1:0] sum_out;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         id;
    logic         cout;
    logic [W-1:0] sum;
  } exp_t;

  exp_t exp_q[$];

  rr_adder_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .a_0(a_0), .b_0(b_0), .cin_0(cin_0),
    .req_1(req_1), .a_1(a_1), .b_1(b_1), .cin_1(cin_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .sel(sel), .busy(busy),
    .sum_out(sum_out), .cout_out(cout_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  // Scoreboard: every response must match the oldest expected entry.
  always @(negedge clk) begin
    if (rsp_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected response id=%0d sum=%02h cout=%0d", rsp_id, sum_out, cout_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({rsp_id, cout_out, sum_out} !== {e.id, e.cout, e.sum}) begin
          errors++;
          $display("FAIL scoreboard: got id=%0d cout=%0d sum=%02h, want id=%0d cout=%0d sum=%02h",
                   rsp_id, cout_out, sum_out, e.id, e.cout, e.sum);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    logic [W:0] full;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.id   = id;
    e.cout = full[W];
    e.sum  = full[W-1:0];
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_0 = 0; req_1 = 0;
    a_0 = '0; b_0 = '0; cin_0 = 0; a_1 = '0; b_1 = '0; cin_1 = 0;
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if ({gnt_0, gnt_1, sel, busy, sum_out, cout_out, rsp_valid, rsp_id} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outputs=%b, want all zero", i,
                 {gnt_0, gnt_1, sel, busy, sum_out, cout_out, rsp_valid, rsp_id});
      end
    end
  endtask

  task automatic test_single();
    req_0 = 1; a_0 = 8'h12; b_0 = 8'h34; cin_0 = 1;
    push_exp(1'b0, 8'h12, 8'h34, 1'b1);
    cyc();
    checks++;
    if ({gnt_0, gnt_1, busy, sel} !== 4'b1010) begin
      errors++;
      $display("FAIL single_grant: gnt_0/gnt_1/busy/sel=%b, want 1010", {gnt_0, gnt_1, busy, sel});
    end
    req_0 = 0;
    cyc();
    checks++;
    if ({rsp_valid, gnt_0, sum_out, cout_out, rsp_id, sel} !== {1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp: valid=%0d gnt_0=%0d sum=%02h cout=%0d id=%0d sel=%0d, want 1 0 47 0 0 0",
               rsp_valid, gnt_0, sum_out, cout_out, rsp_id, sel);
    end
    cyc();
    checks++;
    if ({rsp_valid, busy, sum_out} !== {1'b0, 1'b0, 8'h47}) begin
      errors++;
      $display("FAIL single_done: valid=%0d busy=%0d sum=%02h, want 0 0 47", rsp_valid, busy, sum_out);
    end
  endtask

  task automatic test_overflow();
    req_1 = 1; a_1 = 8'hFF; b_1 = 8'h01; cin_1 = 0;
    push_exp(1'b1, 8'hFF, 8'h01, 1'b0);
    cyc();
    checks++;
    if ({gnt_0, gnt_1, sel} !== 3'b011) begin
      errors++;
      $display("FAIL overflow_grant: gnt_0/gnt_1/sel=%b, want 011", {gnt_0, gnt_1, sel});
    end
    req_1 = 0;
    cyc();
    checks++;
    if ({rsp_valid, sum_out, cout_out, rsp_id, sel} !== {1'b1, 8'h00, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overflow_rsp: valid=%0d sum=%02h cout=%0d id=%0d sel=%0d, want 1 00 1 1 1",
               rsp_valid, sum_out, cout_out, rsp_id, sel);
    end
    cyc();
  endtask

  task automatic test_contention();
    int n;
    rst = 1; cyc(); rst = 0;
    req_0 = 1; a_0 = 8'h10; b_0 = 8'h20; cin_0 = 0;
    req_1 = 1; a_1 = 8'hF0; b_1 = 8'h40; cin_1 = 1;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_exp(1'b0, 8'h10, 8'h20, 1'b0);
      else            push_exp(1'b1, 8'hF0, 8'h40, 1'b1);
    end
    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      cyc();
      if (gnt_0 || gnt_1) begin
        checks++;
        if ({gnt_0, gnt_1} !== ((n % 2 == 0) ? 2'b10 : 2'b01) || c != 3 * n) begin
          errors++;
          $display("FAIL contention grant %0d: gnt_0/gnt_1=%b at cycle %0d, want %b at cycle %0d",
                   n, {gnt_0, gnt_1}, c, (n % 2 == 0) ? 2'b10 : 2'b01, 3 * n);
        end
        n++;
        if (n == 4) begin req_0 = 0; req_1 = 0; end
      end
    end
    req_0 = 0; req_1 = 0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL contention_count: grants=%0d, want 4", n);
    end
    cyc(); cyc(); cyc();
  endtask

  task automatic test_busy();
    req_0 = 1; a_0 = 8'h05; b_0 = 8'h07; cin_0 = 0;
    push_exp(1'b0, 8'h05, 8'h07, 1'b0);
    cyc();
    checks++;
    if (gnt_0 !== 1'b1) begin
      errors++;
      $display("FAIL busy_gnt0: gnt_0=%0d, want 1", gnt_0);
    end
    req_0 = 0; req_1 = 1; a_1 = 8'h80; b_1 = 8'h90; cin_1 = 1;
    push_exp(1'b1, 8'h80, 8'h90, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      cyc();
      checks++;
      if (gnt_1 !== (c == 3)) begin
        errors++;
        $display("FAIL busy_gnt1 cycle %0d: gnt_1=%0d, want %0d", c, gnt_1, (c == 3));
      end
    end
    req_1 = 0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset_mid();
    req_0 = 1; a_0 = 8'h33; b_0 = 8'h44; cin_0 = 1;
    cyc();
    checks++;
    if (gnt_0 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_gnt: gnt_0=%0d, want 1", gnt_0);
    end
    rst = 1; req_0 = 0;
    cyc();
    rst = 0;
    checks++;
    if ({gnt_0, gnt_1, sel, busy, sum_out, cout_out, rsp_valid, rsp_id} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: outputs=%b, want all zero",
               {gnt_0, gnt_1, sel, busy, sum_out, cout_out, rsp_valid, rsp_id});
    end
    req_0 = 1; a_0 = 8'h01; b_0 = 8'h02; cin_0 = 0;
    req_1 = 1; a_1 = 8'h03; b_1 = 8'h04; cin_1 = 0;
    push_exp(1'b0, 8'h01, 8'h02, 1'b0);
    cyc();
    checks++;
    if ({gnt_0, gnt_1} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_first: gnt_0/gnt_1=%b, want 10", {gnt_0, gnt_1});
    end
    req_0 = 0; req_1 = 0;
    cyc(); cyc(); cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_busy();
    test_reset_mid();
    cyc(); cyc();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
